seq_mult_32_bit: RTL and testbench

Sequential 32x32 unsigned shift-and-add multiplier producing a 64-bit product. It is the block directly downstream of the team's 32-bit ripple-carry adder and the first consumer of it: one adder instance (a[31:0], b[31:0], c_in, s[31:0], c_out) does the partial-product accumulation, one iteration per clock. A start/busy/done handshake lets a controller launch one multiply and collect the result.

---
 rtl/seq_mult_32_bit.sv | 93 +++++++++
 tb/tb_seq_mult_32_bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_32_bit.sv
// seq_mult_32_bit: 32x32 unsigned shift-and-add multiplier built around one 32-bit ripple-carry adder

// rca_32: 32-bit ripple-carry adder used for partial-product accumulation
module rca_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        c_out
);
    logic [32:0] c;
    assign c[0]  = c_in;
    assign c_out = c[32];
    for (genvar g = 0; g < 32; g++) begin : g_fa
        assign s[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end
endmodule

module seq_mult_32_bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] addend, sum;
    logic        c_out;

    assign addend  = acc_lo_q[0] ? mcand_q : 32'h0;
    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign product = {acc_hi_q, acc_lo_q};

    rca_32 u_add (
        .a     (acc_hi_q),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (c_out)
    );

    // next state: load on accepted start, shift-accumulate for 32 cycles, pulse done once
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = a;
                acc_hi_d = 32'h0;
                acc_lo_d = b;
                count_d  = 6'd0;
                state_d  = RUN;
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = {c_out, sum, acc_lo_q[31:1]};
                count_d              = count_q + 6'd1;
                state_d              = count_q == 6'd31 ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= 32'h0;
            acc_hi_q <= 32'h0;
            acc_lo_q <= 32'h0;
            count_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_seq_mult_32_bit.sv
// tb_seq_mult_32_bit: scenario tasks checking seq_mult_32_bit against a plain-arithmetic product model
module tb_seq_mult_32_bit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    int          vectors = 0;
    int          miscompares = 0;

    seq_mult_32_bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // drive start for one edge, then verify 32 busy cycles, one done pulse, product and its hold
    task automatic run_mult(input logic [31:0] x, input logic [31:0] y, input string nm);
        logic [63:0] exp;
        int          bad;
        exp = model(x, y);
        bad = 0;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int k = 0; k < 32; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k < 31) step();
        end
        check({nm, " busy_window_bad_cycles"}, 64'(bad), 64'd0);
        step();
        check({nm, " done_pulse"}, {62'd0, busy, done}, 64'd1);
        check({nm, " product"}, product, exp);
        step();
        check({nm, " done_cleared"}, {62'd0, busy, done}, 64'd0);
        check({nm, " product_hold"}, product, exp);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset product", product, 64'd0);
    endtask

    task automatic test_basic();
        run_mult(32'd3, 32'd5, "basic");
    endtask

    task automatic test_max();
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    endtask

    task automatic test_zero_identity();
        run_mult(32'h0, 32'hDEAD_BEEF, "zero");
        run_mult(32'h1234_5678, 32'h1, "identity");
    endtask

    task automatic test_start_ignored();
        int extra_done;
        @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        @(negedge clk);
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 6; k < 33; k++) step();
        check("ignore done_pulse", {62'd0, busy, done}, 64'd1);
        check("ignore product", product, 64'd63);
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignore start_in_done busy", {63'd0, busy}, 64'd0);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) extra_done++;
            step();
        end
        check("ignore no_extra_activity", 64'(extra_done), 64'd0);
        check("ignore product_held", product, 64'd63);
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy/done", {62'd0, busy, done}, 64'd0);
        check("midrst product", product, 64'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dones++;
            step();
        end
        check("midrst no_done", 64'(dones), 64'd0);
        run_mult(32'd6, 32'd7, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_mult(32'h0001_0000, 32'h0001_0000, "b2b_first");
        run_mult(32'd5, 32'd5, "b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int n = 0; n < 10; n++) begin
            x = $urandom;
            y = $urandom;
            if (n == 0) x = 32'h8000_0000;
            if (n == 1) y = 32'h8000_0001;
            run_mult(x, y, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_identity();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
